// File: rtl/ploc_sensor_gen_if.sv
// Command channel of the parking-lot sensor generator: one passage request
// (type + per-phase dwell) per valid/ready handshake.
interface ploc_sensor_gen_if #(
  parameter int DWELL_W = 8
);
  logic               cmd_valid;
  logic [1:0]         cmd_type;
  logic [DWELL_W-1:0] dwell;
  logic               cmd_ready;

  modport master (output cmd_valid, cmd_type, dwell, input cmd_ready);
  modport slave  (input cmd_valid, cmd_type, dwell, output cmd_ready);
endinterface

// File: rtl/ploc_sensor_gen.sv
// Two-beam (a, b) car-passage stimulus generator: plays one enter/exit/balk
// sequence per accepted command and pulses done with the detector's inc_dec code.
module ploc_sensor_gen #(
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  ploc_sensor_gen_if.slave cmd,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic [1:0]       expected,
  output logic [CNT_W-1:0] enter_cnt,
  output logic [CNT_W-1:0] exit_cnt
);

  typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, GAP} state_t;

  state_t             state_reg, state_next;
  logic [DWELL_W-1:0] cnt_reg, cnt_next;
  logic [DWELL_W-1:0] d_reg, d_next;
  logic [1:0]         type_reg, type_next;
  logic [1:0]         ab_reg, ab_next;
  logic               done_reg, done_next;
  logic [1:0]         expected_reg, expected_next;
  logic [CNT_W-1:0]   enter_cnt_reg, enter_cnt_next;
  logic [CNT_W-1:0]   exit_cnt_reg, exit_cnt_next;

  // Beam pattern {a,b} for a phase; PH3 of a full passage is PH1 mirrored,
  // while a balk returns to the PH1 pattern (type[1] marks a balk).
  function automatic logic [1:0] phase_ab(input state_t st, input logic [1:0] t);
    logic [1:0] first;
    first = t[0] ? 2'b01 : 2'b10;
    case (st)
      PH1:     return first;
      PH2:     return 2'b11;
      PH3:     return t[1] ? first : {first[0], first[1]};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] inc_dec_code(input logic [1:0] t);
    case (t)
      2'b00:   return 2'b10;
      2'b01:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    d_next         = d_reg;
    type_next      = type_reg;
    done_next      = 1'b0;
    expected_next  = expected_reg;
    enter_cnt_next = enter_cnt_reg;
    exit_cnt_next  = exit_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (cmd.cmd_valid) begin
          state_next = PH1;
          type_next  = cmd.cmd_type;
          // The counter runs D-1 .. 0, so a dwell of 0 behaves as 1 and 2^W-1 cannot overflow.
          d_next     = (cmd.dwell == '0) ? DWELL_W'(1) : cmd.dwell;
          cnt_next   = (cmd.dwell == '0) ? '0 : cmd.dwell - 1'b1;
        end
      end
      default: begin
        if (cnt_reg == '0) begin
          cnt_next = d_reg - 1'b1;
          case (state_reg)
            PH1:     state_next = PH2;
            PH2:     state_next = PH3;
            PH3:     state_next = GAP;
            default: begin
              state_next    = IDLE;
              done_next     = 1'b1;
              expected_next = inc_dec_code(type_reg);
              if (type_reg == 2'b00) enter_cnt_next = enter_cnt_reg + 1'b1;
              if (type_reg == 2'b01) exit_cnt_next  = exit_cnt_reg + 1'b1;
            end
          endcase
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
    endcase
    ab_next = phase_ab(state_next, type_next);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      d_reg         <= DWELL_W'(1);
      type_reg      <= 2'b00;
      ab_reg        <= 2'b00;
      done_reg      <= 1'b0;
      expected_reg  <= 2'b00;
      enter_cnt_reg <= '0;
      exit_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      d_reg         <= d_next;
      type_reg      <= type_next;
      ab_reg        <= ab_next;
      done_reg      <= done_next;
      expected_reg  <= expected_next;
      enter_cnt_reg <= enter_cnt_next;
      exit_cnt_reg  <= exit_cnt_next;
    end
  end

  assign cmd.cmd_ready = (state_reg == IDLE);
  assign busy          = (state_reg != IDLE);
  assign a             = ab_reg[1];
  assign b             = ab_reg[0];
  assign done          = done_reg;
  assign expected      = expected_reg;
  assign enter_cnt     = enter_cnt_reg;
  assign exit_cnt      = exit_cnt_reg;

endmodule

// File: tb/tb_ploc_sensor_gen.sv
// Directed bench for ploc_sensor_gen: enter/exit/balk sequences, back-to-back
// commands, maximum dwell, asynchronous reset mid-passage and counter wrap.
module tb_ploc_sensor_gen;
  localparam int DW = 8;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ploc_sensor_gen_if #(.DWELL_W(DW)) cmd_if ();

  logic          a, b, busy, done;
  logic [1:0]    expected;
  logic [CW-1:0] enter_cnt, exit_cnt;

  ploc_sensor_gen #(.DWELL_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (cmd_if),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .expected  (expected),
    .enter_cnt (enter_cnt),
    .exit_cnt  (exit_cnt)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]    ab_tbl [4][3];
  logic [1:0]    code_tbl [4];
  logic [1:0]    exp_code  = 2'b00;
  logic [CW-1:0] exp_enter = '0;
  logic [CW-1:0] exp_exit  = '0;
  int            e0, e1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] t, input logic [DW-1:0] d);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_type  = t;
    cmd_if.dwell     = d;
    chk("ready_before_accept", 8'(cmd_if.cmd_ready), 8'd1);
    step();
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Entered in the first PH1 cycle; leaves the bench in the done cycle.
  task automatic run_seq(input logic [1:0] t, input int d);
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < d; i++) begin
        chk($sformatf("ab t%0d p%0d c%0d", t, p, i), 8'({a, b}),
            8'((p < 3) ? ab_tbl[t][p] : 2'b00));
        chk($sformatf("busy t%0d p%0d c%0d", t, p, i), 8'(busy), 8'd1);
        chk($sformatf("done_low t%0d p%0d c%0d", t, p, i), 8'(done), 8'd0);
        step();
      end
    end
    if (t == 2'b00) exp_enter = exp_enter + 1'b1;
    if (t == 2'b01) exp_exit  = exp_exit + 1'b1;
    exp_code = code_tbl[t];
    chk($sformatf("done t%0d", t), 8'(done), 8'd1);
    chk($sformatf("expected t%0d", t), 8'(expected), 8'(exp_code));
    chk($sformatf("ready_done t%0d", t), 8'(cmd_if.cmd_ready), 8'd1);
    chk($sformatf("ab_done t%0d", t), 8'({a, b}), 8'd0);
    chk($sformatf("enter_cnt t%0d", t), 8'(enter_cnt), 8'(exp_enter));
    chk($sformatf("exit_cnt t%0d", t), 8'(exit_cnt), 8'(exp_exit));
  endtask

  initial begin
    ab_tbl[0] = '{2'b10, 2'b11, 2'b01};
    ab_tbl[1] = '{2'b01, 2'b11, 2'b10};
    ab_tbl[2] = '{2'b10, 2'b11, 2'b10};
    ab_tbl[3] = '{2'b01, 2'b11, 2'b01};
    code_tbl  = '{2'b10, 2'b01, 2'b00, 2'b00};
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_type  = 2'b00;
    cmd_if.dwell     = '0;

    #2 reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_a", 8'(a), 8'd0);
    chk("rst_b", 8'(b), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_expected", 8'(expected), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_ready", 8'(cmd_if.cmd_ready), 8'd1);
    chk("rst_enter_cnt", 8'(enter_cnt), 8'd0);
    chk("rst_exit_cnt", 8'(exit_cnt), 8'd0);
    reset = 1'b1;
    step();

    // Enter, dwell 2
    issue(2'b00, 8'd2);
    run_seq(2'b00, 2);
    step();
    chk("done_clears", 8'(done), 8'd0);
    chk("expected_holds", 8'(expected), 8'h2);

    // Exit, dwell 0 treated as 1
    issue(2'b01, 8'd0);
    run_seq(2'b01, 1);
    step();

    // Balk-enter then balk-exit, dwell 1
    issue(2'b10, 8'd1);
    run_seq(2'b10, 1);
    step();
    issue(2'b11, 8'd1);
    run_seq(2'b11, 1);
    chk("balk_enter_cnt", 8'(enter_cnt), 8'd1);
    chk("balk_exit_cnt", 8'(exit_cnt), 8'd1);
    step();

    // cmd_valid held, cmd_type changed mid-sequence, dwell 3
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_type  = 2'b00;
    cmd_if.dwell     = 8'd3;
    e0 = cyc;
    step();
    cmd_if.cmd_type = 2'b01;
    run_seq(2'b00, 3);
    e1 = cyc;
    step();
    cmd_if.cmd_valid = 1'b0;
    chk("cmd_period", 8'(e1 - e0), 8'd13);
    run_seq(2'b01, 3);
    step();

    // Maximum dwell on a balk
    issue(2'b10, 8'd255);
    run_seq(2'b10, 255);
    step();

    // Asynchronous reset during PH2 of an enter
    issue(2'b00, 8'd2);
    step();
    step();
    chk("pre_reset_ph2", 8'({a, b}), 8'h3);
    #1 reset = 1'b0;
    #1;
    chk("async_ab", 8'({a, b}), 8'd0);
    chk("async_busy", 8'(busy), 8'd0);
    chk("async_done", 8'(done), 8'd0);
    chk("async_enter_cnt", 8'(enter_cnt), 8'd0);
    chk("async_exit_cnt", 8'(exit_cnt), 8'd0);
    exp_enter = '0;
    exp_exit  = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    step();

    // Five enters wrap a 2-bit counter to 1
    for (int n = 0; n < 5; n++) begin
      issue(2'b00, 8'((n == 0) ? 2 : 1));
      run_seq(2'b00, (n == 0) ? 2 : 1);
      step();
    end
    chk("wrap_enter_cnt", 8'(enter_cnt), 8'd1);
    chk("wrap_exit_cnt", 8'(exit_cnt), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ploc_sensor_gen.md
# ploc_sensor_gen

Parking-lot sensor stimulus generator: the transmit side of the two-beam (a, b) car-passage interface that the occupancy detector decodes. It accepts one passage command at a time over a valid/ready handshake and drives the glitch-free a/b phase sequence for an entering car, an exiting car, or a car that balks and backs out. On completion it pulses `done` with the `inc_dec` code the detector must report. It serves as the lot-side emulator in system benches and on-board self-test.

## Interface
- `DWELL_W`, 8: width of the per-phase dwell count.
- `CNT_W`, 8: width of the completed-passage counters.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low (asserted at 0).
- `cmd_valid` in 1: command present.
- `cmd_type` in 2: 00 enter, 01 exit, 10 balk-enter, 11 balk-exit.
- `dwell` in DWELL_W: cycles per phase; 0 is treated as 1.
- `cmd_ready` out 1: generator idle, command accepted this edge if `cmd_valid`.
- `a` out 1: outer beam, registered.
- `b` out 1: inner beam, registered.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle completion pulse.
- `expected` out 2: `inc_dec` code for the finished passage, valid while `done`=1; 2'b10 enter, 2'b01 exit, 2'b00 balk.
- `enter_cnt` out CNT_W: completed enter passages, wraps modulo 2^CNT_W.
- `exit_cnt` out CNT_W: completed exit passages, wraps modulo 2^CNT_W.

## Operation
- States: IDLE, PH1, PH2, PH3, GAP.
- IDLE: `cmd_ready`=1, `busy`=0, a=b=0.
- Accept on a rising edge with `cmd_valid`&&`cmd_ready`:
  - latch `cmd_type` and D = max(`dwell`,1);
  - go to PH1 and load the dwell counter.
- Phase a/b values as (a,b):
  - enter: PH1 10, PH2 11, PH3 01.
  - exit: PH1 01, PH2 11, PH3 10.
  - balk-enter: PH1 10, PH2 11, PH3 10.
  - balk-exit: PH1 01, PH2 11, PH3 01.
- Each of PH1, PH2, PH3 and GAP lasts exactly D cycles. GAP holds a=b=0.
- After GAP the FSM returns to IDLE. In that first IDLE cycle `done`=1 and `expected` shows the latched code.
- On the edge that ends GAP:
  - enter increments `enter_cnt`;
  - exit increments `exit_cnt`;
  - balks change neither counter.
- Inputs are ignored while `busy`. There is no queue, so the source holds `cmd_valid` until `cmd_ready`.
- a and b come straight from flops and change only on state/phase edges. Adjacent phases differ in exactly one beam (Gray-ordered).

## Timing
- Reset values: a=0, b=0, `done`=0, `expected`=00, `busy`=0, `cmd_ready`=1, `enter_cnt`=0, `exit_cnt`=0, state IDLE.
- `cmd_ready` is combinational from state (IDLE). `busy` is its inverse.
- Command accepted at edge k:
  - PH1 values visible in cycles k+1..k+D;
  - PH2 in k+D+1..k+2D;
  - PH3 in k+2D+1..k+3D;
  - GAP (00) in k+3D+1..k+4D;
  - `done`=1 and `cmd_ready`=1 in cycle k+4D+1;
  - counters show the new value from cycle k+4D+1.
- A command accepted in the `done` cycle starts PH1 on the next cycle. Minimum command period is 4D+1 cycles, with a 00 interval of at least D+1 cycles between passages.
- `expected` holds its last value until the next `done`.
- `dwell` = 2^DWELL_W-1 is legal. The dwell counter must not overflow.
- Reset asserted mid-sequence immediately forces a=b=0, `done`=0, state IDLE and counters 0 (asynchronous). Deassertion takes effect at the next rising edge. The interrupted passage is not counted.

## Test plan
- Enter, `dwell`=2: a,b = 10,10,11,11,01,01,00,00; then `done`=1, `expected`=2'b10, `enter_cnt`=1, `exit_cnt`=0.
- Exit, `dwell`=0 (treated as 1): a,b = 01,11,10,00; `done` on the 5th cycle after accept, `expected`=2'b01, `exit_cnt`=1.
- Balk-enter then balk-exit, `dwell`=1: sequences 10,11,10,00 and 01,11,01,00; `expected`=00 both times; both counters unchanged.
- `cmd_valid` held high with `cmd_type` toggled mid-sequence, `dwell`=3: the in-flight passage is unaffected; the next passage is accepted in the `done` cycle; period is 13 cycles.
- `reset` driven low during PH2 of an enter: a=b=0 and `busy`=0 without waiting for a clock edge; `enter_cnt` stays 0; a new enter afterwards completes normally.
- `CNT_W`=2: five enter passages leave `enter_cnt`=1, confirming wrap-around.
